// File: rtl/ring_buffer_write_arbiter_pkg.sv
// Shared types and helpers for the ring-buffer write arbiter and its picker.
package ring_buffer_write_arbiter_pkg;

  typedef enum logic {
    ArbIdle  = 1'b0,
    ArbBurst = 1'b1
  } arb_state_e;

  // Index width for an n-entry requester vector; never narrower than one bit.
  function automatic int rr_index_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ring_buffer_write_arbiter_picker.sv
// Round-robin priority picker: first asserted request at or after start, with wrap.
module rr_priority_picker
  import ring_buffer_write_arbiter_pkg::*;
#(
  parameter int NumRequesters = 4,
  localparam int IdxW = rr_index_width(NumRequesters)
) (
  input  logic [NumRequesters-1:0] req,
  input  logic [IdxW-1:0]          start,
  output logic                     found,
  output logic [IdxW-1:0]          index
);

  always_comb begin
    int pos;
    logic [IdxW-1:0] pos_idx;
    found   = 1'b0;
    index   = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 0; k < NumRequesters; k++) begin
      pos     = (int'(start) + k) % NumRequesters;
      pos_idx = IdxW'(pos);
      if (!found && req[pos_idx]) begin
        found = 1'b1;
        index = pos_idx;
      end
    end
  end

endmodule

// File: rtl/ring_buffer_write_arbiter.sv
// Shares one ring_buffer put port among several valid/ready producers, round-robin with bounded bursts.
module ring_buffer_write_arbiter
  import ring_buffer_write_arbiter_pkg::*;
#(
  parameter int WordLengthBits = 8,
  parameter int NumRequesters  = 4,
  parameter int MaxBurst       = 4,
  localparam int GrantIdW = rr_index_width(NumRequesters)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NumRequesters-1:0]              req_valid,
  input  logic [NumRequesters*WordLengthBits-1:0] req_data,
  output logic [NumRequesters-1:0]              req_ready,
  input  logic                                  buffer_100p_full,
  output logic                                  put,
  output logic [WordLengthBits-1:0]             data_in,
  output logic                                  grant_valid,
  output logic [GrantIdW-1:0]                   grant_id
);

  localparam int CntW = $clog2(MaxBurst + 1);
  localparam logic [CntW-1:0] LastBeat = CntW'(MaxBurst - 1);
  localparam logic [GrantIdW-1:0] LastId = GrantIdW'(NumRequesters - 1);

  arb_state_e          state_q, state_d;
  logic                grant_valid_q, grant_valid_d;
  logic [GrantIdW-1:0] grant_id_q, grant_id_d;
  logic [CntW-1:0]     burst_cnt_q, burst_cnt_d;
  logic [GrantIdW-1:0] rr_ptr_q, rr_ptr_d;

  logic                cur_valid;
  logic                ready_gate;
  logic                do_release;
  logic [GrantIdW-1:0] pick_start;
  logic                pick_found;
  logic [GrantIdW-1:0] pick_index;

  // Handshake outputs react combinationally to full so a same-cycle get is usable at once.
  always_comb begin
    cur_valid  = req_valid[grant_id_q];
    ready_gate = grant_valid_q && !buffer_100p_full;
    req_ready  = ready_gate ? (NumRequesters'(1) << grant_id_q) : '0;
    put        = ready_gate && cur_valid;
    data_in    = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      if (grant_id_q == GrantIdW'(i)) data_in = req_data[i*WordLengthBits +: WordLengthBits];
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

  // From IDLE search after the last grantee; on release search after the releasing port.
  always_comb begin
    if (state_q == ArbIdle) begin
      pick_start = (rr_ptr_q == LastId) ? '0 : rr_ptr_q + GrantIdW'(1);
    end else begin
      pick_start = (grant_id_q == LastId) ? '0 : grant_id_q + GrantIdW'(1);
    end
  end

  rr_priority_picker #(
    .NumRequesters(NumRequesters)
  ) u_picker (
    .req   (req_valid),
    .start (pick_start),
    .found (pick_found),
    .index (pick_index)
  );

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    burst_cnt_d   = burst_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    do_release    = 1'b0;

    case (state_q)
      ArbIdle: begin
        if (pick_found) begin
          state_d       = ArbBurst;
          grant_valid_d = 1'b1;
          grant_id_d    = pick_index;
          burst_cnt_d   = '0;
        end
      end
      ArbBurst: begin
        if (!cur_valid) begin
          do_release = 1'b1;
        end else if (!buffer_100p_full) begin
          if (burst_cnt_q == LastBeat) do_release = 1'b1;
          else burst_cnt_d = burst_cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d       = ArbIdle;
        grant_valid_d = 1'b0;
      end
    endcase

    // Back-to-back re-grant keeps the put port busy with no dead cycle between bursts.
    if (do_release) begin
      rr_ptr_d    = grant_id_q;
      burst_cnt_d = '0;
      if (pick_found) begin
        grant_id_d = pick_index;
      end else begin
        state_d       = ArbIdle;
        grant_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ArbIdle;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      burst_cnt_q   <= '0;
      rr_ptr_q      <= LastId;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      burst_cnt_q   <= burst_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_ring_buffer_write_arbiter.sv
// Scoreboard bench for ring_buffer_write_arbiter with a behavioural ring-buffer occupancy model.
module tb_ring_buffer_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    int port;
    int data;
  } exp_t;

  logic clk;
  logic rst;
  logic get;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic           buf_full;
  int             buf_cnt;
  int             buf_cap;
  int             act;

  logic [N-1:0] rv0, rv1, rv2, rdy0, rdy1, rdy2;
  logic         put0, put1, put2, gv0, gv1, gv2;
  logic [W-1:0] din0, din1, din2;
  logic [1:0]   gid0, gid1, gid2;

  logic [N-1:0] a_rdy;
  logic         a_put, a_gv;
  logic [W-1:0] a_din;
  logic [1:0]   a_gid;

  logic [7:0] pmem [N][64];
  int         phead [N];
  int         ptail [N];
  exp_t       exp_q [$];
  int         port_cnt [N];
  int         total_puts;
  int         n_cmp;
  int         n_bad;

  logic         s_rst, s_put, s_get;
  logic [N-1:0] s_fire;

  assign rv0 = (act == 0) ? req_valid : '0;
  assign rv1 = (act == 1) ? req_valid : '0;
  assign rv2 = (act == 2) ? req_valid : '0;
  assign buf_full = (buf_cnt >= buf_cap);

  ring_buffer_write_arbiter #(.WordLengthBits(W), .NumRequesters(N), .MaxBurst(4)) u_b4 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_data(req_data), .req_ready(rdy0),
    .buffer_100p_full(buf_full), .put(put0), .data_in(din0), .grant_valid(gv0), .grant_id(gid0));
  ring_buffer_write_arbiter #(.WordLengthBits(W), .NumRequesters(N), .MaxBurst(2)) u_b2 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_data(req_data), .req_ready(rdy1),
    .buffer_100p_full(buf_full), .put(put1), .data_in(din1), .grant_valid(gv1), .grant_id(gid1));
  ring_buffer_write_arbiter #(.WordLengthBits(W), .NumRequesters(N), .MaxBurst(1)) u_b1 (
    .clk(clk), .rst(rst), .req_valid(rv2), .req_data(req_data), .req_ready(rdy2),
    .buffer_100p_full(buf_full), .put(put2), .data_in(din2), .grant_valid(gv2), .grant_id(gid2));

  always_comb begin
    a_rdy = rdy0; a_put = put0; a_din = din0; a_gv = gv0; a_gid = gid0;
    if (act == 1) begin
      a_rdy = rdy1; a_put = put1; a_din = din1; a_gv = gv1; a_gid = gid1;
    end else if (act == 2) begin
      a_rdy = rdy2; a_put = put2; a_din = din2; a_gv = gv2; a_gid = gid2;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, want, want, $time);
    end
  endtask

  // Monitor: sample the handshake at the falling edge and score every accepted put.
  initial begin
    exp_t e;
    total_puts = 0;
    for (int p = 0; p < N; p++) port_cnt[p] = 0;
    s_rst = 1'b1; s_put = 1'b0; s_get = 1'b0; s_fire = '0;
    forever begin
      @(negedge clk);
      s_rst  = rst;
      s_put  = a_put;
      s_get  = get;
      s_fire = req_valid & a_rdy;
      if (!rst && a_put) begin
        total_puts++;
        port_cnt[a_gid]++;
        chk("put_while_full", int'(buf_full), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_put", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("grant_id", int'(a_gid), e.port);
          chk("data_in", int'(a_din), e.data);
          chk("req_ready", int'(a_rdy), 1 << e.port);
        end
      end
    end
  end

  // Producer and ring-buffer model: update right after each rising edge.
  initial begin
    buf_cnt = 0;
    req_valid = '0;
    req_data = '0;
    for (int p = 0; p < N; p++) phead[p] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (s_rst) begin
        buf_cnt = 0;
      end else begin
        for (int p = 0; p < N; p++) if (s_fire[p]) phead[p]++;
        if (s_put && buf_cnt < buf_cap) buf_cnt++;
        if (s_get && buf_cnt > 0) buf_cnt--;
      end
      for (int p = 0; p < N; p++) begin
        req_valid[p] = (phead[p] < ptail[p]);
        req_data[p*W +: W] = pmem[p][phead[p]];
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic load(input int p, input int d);
    pmem[p][ptail[p]] = 8'(d);
    ptail[p]++;
  endtask

  task automatic expect_word(input int p, input int d);
    exp_t e;
    e.port = p;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    int base_tot;
    int base_p [N];
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    get = 1'b0;
    act = 0;
    buf_cap = 64;
    for (int p = 0; p < N; p++) begin
      ptail[p] = 0;
      for (int i = 0; i < 64; i++) pmem[p][i] = 8'h00;
    end
    cyc(2);
    rst = 1'b0;

    // Single requester, MaxBurst=4: entry cycle, 4 words, zero-gap re-grant, 2 words.
    do_reset();
    chk("rst_grant_valid", int'(a_gv), 0);
    chk("rst_grant_id", int'(a_gid), 0);
    chk("rst_put", int'(a_put), 0);
    chk("rst_ready", int'(a_rdy), 0);
    for (int i = 0; i < 6; i++) begin
      load(2, 8'h11 + i);
      expect_word(2, 8'h11 + i);
    end
    cyc(1);
    chk("t1_entry_gv", int'(a_gv), 0);
    cyc(1);
    chk("t1_gv", int'(a_gv), 1);
    chk("t1_gid", int'(a_gid), 2);
    for (int i = 0; i < 6; i++) begin
      chk("t1_put_b2b", int'(a_put), 1);
      cyc(1);
    end
    chk("t1_put_done", int'(a_put), 0);
    cyc(1);
    chk("t1_idle", int'(a_gv), 0);

    // Four ports continuously valid, MaxBurst=2: pairs in round-robin order.
    act = 1;
    do_reset();
    for (int p = 0; p < N; p++) for (int i = 0; i < 10; i++) load(p, p*16 + i);
    for (int b = 0; b < 5; b++)
      for (int p = 0; p < N; p++)
        for (int j = 0; j < 2; j++) expect_word(p, p*16 + b*2 + j);
    cyc(2);
    base_tot = total_puts;
    for (int p = 0; p < N; p++) base_p[p] = port_cnt[p];
    cyc(40);
    chk("t2_total_words", total_puts - base_tot, 40);
    for (int p = 0; p < N; p++) chk("t2_share", port_cnt[p] - base_p[p], 10);
    chk("t2_put_done", int'(a_put), 0);

    // Back-pressure: 4-word buffer, no gets until the grant has been held.
    act = 0;
    buf_cap = 4;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      load(1, 8'h21 + i);
      expect_word(1, 8'h21 + i);
    end
    cyc(2);
    chk("t3_first_put", int'(a_put), 1);
    cyc(4);
    chk("t3_full", int'(buf_full), 1);
    chk("t3_put_blocked", int'(a_put), 0);
    chk("t3_ready_blocked", int'(a_rdy), 0);
    chk("t3_grant_held", int'(a_gv), 1);
    chk("t3_gid_held", int'(a_gid), 1);
    cyc(2);
    chk("t3_still_held", int'(a_gv), 1);
    chk("t3_still_blocked", int'(a_put), 0);
    get = 1'b1;
    cyc(1);
    get = 1'b0;
    chk("t3_one_put", int'(a_put), 1);
    cyc(1);
    chk("t3_refull_put", int'(a_put), 0);
    get = 1'b1;
    cyc(6);
    get = 1'b0;
    cyc(2);
    chk("t3_drained", exp_q.size(), 0);
    buf_cap = 64;

    // Early release: port 0 has a single word, port 3 waits.
    do_reset();
    load(0, 8'hA0);
    load(3, 8'h30);
    load(3, 8'h31);
    expect_word(0, 8'hA0);
    expect_word(3, 8'h30);
    expect_word(3, 8'h31);
    cyc(2);
    chk("t4_gid0", int'(a_gid), 0);
    chk("t4_put0", int'(a_put), 1);
    cyc(1);
    chk("t4_drop_gid", int'(a_gid), 0);
    chk("t4_drop_put", int'(a_put), 0);
    cyc(1);
    chk("t4_gid3", int'(a_gid), 3);
    chk("t4_put3", int'(a_put), 1);
    cyc(3);

    // Reset after two words of a four-word burst from port 1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load(1, 8'h40 + i);
      expect_word(1, 8'h40 + i);
    end
    expect_word(3, 8'h50);
    expect_word(3, 8'h51);
    cyc(4);
    chk("t5_mid_burst_put", int'(a_put), 1);
    rst = 1'b1;
    load(3, 8'h50);
    load(3, 8'h51);
    cyc(1);
    chk("t5_rst_gv", int'(a_gv), 0);
    chk("t5_rst_put", int'(a_put), 0);
    rst = 1'b0;
    cyc(1);
    chk("t5_first_gid", int'(a_gid), 1);
    chk("t5_first_gv", int'(a_gv), 1);
    cyc(6);

    // MaxBurst=1: strict alternation between ports 0 and 2.
    act = 2;
    do_reset();
    load(0, 8'h60);
    load(0, 8'h61);
    load(2, 8'h62);
    load(2, 8'h63);
    expect_word(0, 8'h60);
    expect_word(2, 8'h62);
    expect_word(0, 8'h61);
    expect_word(2, 8'h63);
    cyc(2);
    for (int i = 0; i < 4; i++) begin
      chk("t6_put_b2b", int'(a_put), 1);
      chk("t6_gid", int'(a_gid), (i % 2 == 0) ? 0 : 2);
      cyc(1);
    end
    chk("t6_put_done", int'(a_put), 0);
    cyc(2);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
